// File: rtl/sp_ram_req_ctrl.sv
// Single-port SRAM request controller: valid/ready requests in, 2-deep read response FIFO out.
// Optional power-up fill of every word with INIT_VALUE when SP_RAM_CTRL_INIT_EN is defined.
module sp_ram_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bw,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_di,
  output logic [DATA_WIDTH-1:0] mem_bw,
  output logic                  mem_ce,
  output logic                  mem_rdwen,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [1:0]            occ;
  logic                  rd_pend;
  logic                  wp;
  logic                  rp;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic                  run;
  logic                  pop;
  logic                  accept;
  logic                  init_wr;
  logic [2:0]            credit;

  assign run       = (state == ST_RUN);
  assign pop       = rsp_valid & rsp_ready;
  // slots already owed: buffered + in flight, minus what leaves this cycle
  assign credit    = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
  assign req_ready = run & (credit < 3'd2);
  assign accept    = req_valid & req_ready;
  assign init_done = run;

`ifdef SP_RAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt;

  assign init_wr = (state == ST_INIT) & ~RST;
  assign mem_a   = init_wr ? init_cnt : req_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == {ADDR_WIDTH{1'b1}})
        state <= ST_RUN;
    end
  end
`else
  assign init_wr = 1'b0;
  assign mem_a   = req_addr;

  always_ff @(posedge CLK) begin
    if (RST)
      state <= ST_INIT;
    else
      state <= ST_RUN;
  end
`endif

  assign mem_ce    = accept | init_wr;
  assign mem_di    = init_wr ? INIT_VALUE : req_wdata;
  assign mem_bw    = init_wr ? {DATA_WIDTH{1'b1}} : req_bw;
  assign mem_rdwen = init_wr | req_we;

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ     <= '0;
      rd_pend <= 1'b0;
      wp      <= 1'b0;
      rp      <= 1'b0;
    end else begin
      rd_pend <= accept & ~req_we;
      occ     <= occ + {1'b0, rd_pend} - {1'b0, pop};
      if (rd_pend)
        wp <= ~wp;
      if (pop)
        rp <= ~rp;
    end
  end

  // mem_do only looked at the cycle after a read strobe
  always_ff @(posedge CLK) begin
    if (rd_pend) begin
      if (wp)
        q1 <= mem_do;
      else
        q0 <= mem_do;
    end
  end

  assign rsp_valid = (occ != 2'd0);
  assign rsp_rdata = rp ? q1 : q0;

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Directed testbench for sp_ram_req_ctrl with a behavioural single-port SRAM.
// Build with SP_RAM_CTRL_INIT_EN defined to exercise the init sweep (ADDR_WIDTH=4).
module tb_sp_ram_req_ctrl;

`ifdef SP_RAM_CTRL_INIT_EN
  localparam int AW = 4;
  localparam int INIT_CYC = 16;
`else
  localparam int AW = 8;
  localparam int INIT_CYC = 1;
`endif
  localparam int DW = 32;
  localparam logic [DW-1:0] IV = 32'hA5A5A5A5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_bw;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_bw;
  logic          mem_ce;
  logic          mem_rdwen;
  logic [DW-1:0] mem_do;

  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] got [$];
  int checks = 0;
  int fails = 0;

  sp_ram_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .INIT_VALUE(IV)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bw(req_bw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_a(mem_a), .mem_di(mem_di), .mem_bw(mem_bw),
    .mem_ce(mem_ce), .mem_rdwen(mem_rdwen), .mem_do(mem_do)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_ce) begin
      if (mem_rdwen)
        sram[mem_a] <= (sram[mem_a] & ~mem_bw) | (mem_di & mem_bw);
      else
        mem_do <= sram[mem_a];
    end
  end

  always @(negedge CLK) begin
    if (!RST && rsp_valid && rsp_ready)
      got.push_back(rsp_rdata);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_req(input logic we, input int a,
                        input logic [DW-1:0] d, input logic [DW-1:0] bw);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = AW'(a);
    req_wdata = d;
    req_bw = bw;
    #1;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (w >= 50) begin
      fails++;
      $display("FAIL req_accept_timeout: addr %0d never accepted, required accept within 50", a);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int w;
    w = 0;
    while (got.size() < n && w < 100) begin
      tick();
      w++;
    end
    checks++;
    if (got.size() < n) begin
      fails++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", got.size(), n);
    end
  endtask

  task automatic test_reset();
    int n;
    RST = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_bw = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, rsp_valid, init_done, mem_ce} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: ready/valid/done/ce = %b, required 0000",
               {req_ready, rsp_valid, init_done, mem_ce});
    end
    RST = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != INIT_CYC) begin
      fails++;
      $display("FAIL init_latency: init_done after %0d cycles, required %0d", n, INIT_CYC);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_init: req_ready=%b, required 1", req_ready);
    end
  endtask

`ifdef SP_RAM_CTRL_INIT_EN
  task automatic test_init();
    got.delete();
    rsp_ready = 1'b1;
    do_req(1'b0, 0, '0, '0);
    do_req(1'b0, 15, '0, '0);
    wait_rsp(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got.size() > i && got[i] !== IV) begin
        fails++;
        $display("FAIL init_value[%0d]: got %h, required %h", i, got[i], IV);
      end
    end
  endtask
`endif

  task automatic test_write_read();
    got.delete();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = AW'(5);
    req_wdata = 32'hDEADBEEF;
    req_bw = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({req_ready, mem_ce, mem_rdwen} !== 3'b111 || mem_a !== AW'(5)) begin
      fails++;
      $display("FAIL write_issue: ready/ce/rdwen=%b a=%h, required 111 a=05",
               {req_ready, mem_ce, mem_rdwen}, mem_a);
    end
    tick();
    req_we = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_ce, mem_rdwen} !== 3'b110) begin
      fails++;
      $display("FAIL read_issue: ready/ce/rdwen=%b, required 110",
               {req_ready, mem_ce, mem_rdwen});
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_latency_early: rsp_valid=%b at t+1, required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_read: valid=%b data=%h, required 1 deadbeef", rsp_valid, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL head_stable: valid=%b data=%h, required 1 deadbeef", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || got.size() != 1) begin
      fails++;
      $display("FAIL pop_single: valid=%b pops=%0d, required 0 1", rsp_valid, got.size());
    end
  endtask

  task automatic test_partial_write();
    got.delete();
    rsp_ready = 1'b1;
    do_req(1'b1, 5, 32'h12345678, 32'h0000FFFF);
    do_req(1'b0, 5, '0, '0);
    wait_rsp(1);
    checks++;
    if (got.size() > 0 && got[0] !== 32'hDEAD5678) begin
      fails++;
      $display("FAIL partial_write: got %h, required dead5678", got[0]);
    end
  endtask

  task automatic test_streaming();
    int drops;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      do_req(1'b1, i, 32'(i * 3), 32'hFFFFFFFF);
    got.delete();
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = AW'(i);
      #1;
      if (!req_ready)
        drops++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (drops != 0) begin
      fails++;
      $display("FAIL stream_ready: req_ready low %0d cycles, required 0", drops);
    end
    wait_rsp(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got.size() > i && got[i] !== 32'(i * 3)) begin
        fails++;
        $display("FAIL stream_data[%0d]: got %h, required %h", i, got[i], 32'(i * 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int w;
    logic acc;
    logic [DW-1:0] exp_d [4];
    got.delete();
    rsp_ready = 1'b0;
    req_we = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr = AW'(idx);
      #1;
      acc = req_ready;
      tick();
      if (acc)
        idx++;
    end
    req_addr = AW'(idx);
    #1;
    checks++;
    if (idx != 2 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: accepted %0d ready=%b, required 2 0", idx, req_ready);
    end
    rsp_ready = 1'b1;
    w = 0;
    while (idx < 4 && w < 50) begin
      req_addr = AW'(idx);
      #1;
      acc = req_ready;
      tick();
      if (acc)
        idx++;
      w++;
    end
    req_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      fails++;
      $display("FAIL bp_resume: accepted %0d, required 4", idx);
    end
    wait_rsp(4);
    exp_d[0] = 32'd0;
    exp_d[1] = 32'd3;
    exp_d[2] = 32'd6;
    exp_d[3] = 32'd9;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() > i && got[i] !== exp_d[i]) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %h, required %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          we_v [5];
    int            a_v [5];
    logic [DW-1:0] d_v [5];
    logic [DW-1:0] exp_d [3];
    int drops;
    we_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    a_v  = '{7, 7, 0, 2, 1};
    d_v  = '{32'h11112222, 32'h0, 32'h0, 32'hCAFE0000, 32'h0};
    exp_d = '{32'h11112222, 32'd0, 32'd3};
    got.delete();
    rsp_ready = 1'b1;
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_we = we_v[i];
      req_addr = AW'(a_v[i]);
      req_wdata = d_v[i];
      req_bw = 32'hFFFFFFFF;
      #1;
      if (!req_ready)
        drops++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (drops != 0) begin
      fails++;
      $display("FAIL b2b_ready: req_ready low %0d cycles, required 0", drops);
    end
    wait_rsp(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() > i && got[i] !== exp_d[i]) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h, required %h", i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int w;
    got.delete();
    rsp_ready = 1'b1;
    do_req(1'b0, 1, '0, '0);
    RST = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_flush: rsp_valid=%b, required 0", rsp_valid);
    end
    tick();
    RST = 1'b0;
    w = 0;
    while (init_done !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    repeat (5) tick();
    checks++;
    if (rsp_valid !== 1'b0 || got.size() != 0) begin
      fails++;
      $display("FAIL rst_stale: valid=%b responses=%0d, required 0 0", rsp_valid, got.size());
    end
  endtask

  initial begin
    test_reset();
`ifdef SP_RAM_CTRL_INIT_EN
    test_init();
`endif
    test_write_read();
    test_partial_write();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
